// File: rtl/debounce_pkg.sv
// Shared defaults and per-channel FSM encoding for the multi-channel
// button debouncer.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 100;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    HELD = 2'd2
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, symmetric stable-count filter,
// press/release pulses and a one-shot long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic [HW-1:0]          r_hold;
  logic [HW-1:0]          w_hold_next;
  ch_state_e              r_state;
  ch_state_e              w_state_next;
  logic                   w_s;
  logic                   w_differ;
  logic                   w_toggle;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_long_set;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_differ = w_s ^ r_level;
  assign w_toggle = w_differ && (r_cnt == CNT_LAST);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  // Any sample agreeing with the current level restarts the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pb};
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOW;
      r_hold  <= '0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_long  <= w_long_set;
    end
  end

  // A release on the same edge the hold would expire wins: no long pulse.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    case (r_state)
      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_hold_next  = '0;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_next = LOW;
        end else begin
          w_hold_next = r_hold + 1'b1;
          if (w_hold_next == HOLD_LAST) begin
            w_state_next = HELD;
          end
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_next = LOW;
        end
      end
      default: begin
        w_state_next = LOW;
      end
    endcase
  end

  always_comb begin
    w_long_set = (r_state == HIGH) && (w_state_next == HELD);
  end

  assign pb_debounced  = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;

endmodule

// File: rtl/debounce_onepulse_multi.sv
// N_CH independent debounce channels with per-channel press, release and
// long-press pulses.
module debounce_onepulse_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_debounced,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .pb           (pb[gi]),
        .pb_debounced (pb_debounced[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi]),
        .long_pulse   (long_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_onepulse_multi.sv
// Randomised and directed bench for debounce_onepulse_multi, checked every
// cycle against a history-based reference model through a scoreboard queue.
module tb_debounce_onepulse_multi;

  localparam int N    = 4;
  localparam int ST   = 4;
  localparam int HOLD = 10;
  localparam int SYNC = 2;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pb;
  logic [N-1:0] pb_debounced;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  always #5 clk = ~clk;

  debounce_onepulse_multi #(
    .N_CH         (N),
    .STABLE_CYCLES(ST),
    .HOLD_CYCLES  (HOLD),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pb           (pb),
    .pb_debounced (pb_debounced),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  typedef struct packed {
    int           e;
    logic [N-1:0] deb;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  // Reference model: raw input history plus per-channel level and last event edge.
  logic [N-1:0] pb_hist [MAXE];
  int           edge_n   = 0;
  int           last_rst = 0;
  logic [N-1:0] lvl      = '0;
  int           last_evt [N];
  int           press_at [N];

  // Observed DUT events (actual values only).
  int press_e [N];
  int rel_e   [N];
  int long_e  [N];
  int press_n [N];
  int rel_n   [N];
  int long_n  [N];

  function automatic logic s_at(input int ch, input int e);
    if (e - SYNC > last_rst) return pb_hist[e - SYNC][ch];
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] p);
    exp_t ex;
    logic tog;
    @(negedge clk);
    rst = r;
    pb  = p;
    @(posedge clk);
    edge_n++;
    pb_hist[edge_n] = p;
    ex   = '0;
    ex.e = edge_n;
    if (r) begin
      last_rst = edge_n;
      lvl      = '0;
      for (int ch = 0; ch < N; ch++) begin
        last_evt[ch] = edge_n;
        press_at[ch] = -1;
      end
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        tog = 1'b0;
        if (edge_n - last_evt[ch] >= ST) begin
          tog = 1'b1;
          for (int k = 0; k < ST; k++)
            if (s_at(ch, edge_n - k) == lvl[ch]) tog = 1'b0;
        end
        if (tog) begin
          lvl[ch]      = ~lvl[ch];
          last_evt[ch] = edge_n;
          if (lvl[ch]) begin
            ex.pr[ch]    = 1'b1;
            press_at[ch] = edge_n;
          end else begin
            ex.rl[ch] = 1'b1;
          end
        end else if (lvl[ch] && press_at[ch] >= 0 && edge_n - press_at[ch] == HOLD - 1) begin
          ex.lg[ch] = 1'b1;
        end
      end
    end
    ex.deb = lvl;
    exp_q.push_back(ex);
  endtask

  task automatic run(input int n, input logic [N-1:0] p);
    for (int i = 0; i < n; i++) step(1'b0, p);
  endtask

  task automatic check(input string nm, input int act, input int req);
    cmp_cnt++;
    if (act != req) begin
      err_cnt++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t ex;
    logic [4*N-1:0] got;
    logic [4*N-1:0] want;
    if (exp_q.size() != 0) begin
      ex   = exp_q.pop_front();
      got  = {pb_debounced, press_pulse, release_pulse, long_pulse};
      want = {ex.deb, ex.pr, ex.rl, ex.lg};
      cmp_cnt++;
      if (got !== want) begin
        err_cnt++;
        $display("FAIL outputs@edge%0d: got deb=%b pr=%b rl=%b lg=%b, required deb=%b pr=%b rl=%b lg=%b",
                 ex.e, pb_debounced, press_pulse, release_pulse, long_pulse,
                 ex.deb, ex.pr, ex.rl, ex.lg);
      end
      for (int ch = 0; ch < N; ch++) begin
        if (press_pulse[ch] === 1'b1) begin
          press_e[ch] = ex.e;
          press_n[ch]++;
          $display("edge %0d ch%0d press", ex.e, ch);
        end
        if (release_pulse[ch] === 1'b1) begin
          rel_e[ch] = ex.e;
          rel_n[ch]++;
          $display("edge %0d ch%0d release", ex.e, ch);
        end
        if (long_pulse[ch] === 1'b1) begin
          long_e[ch] = ex.e;
          long_n[ch]++;
          $display("edge %0d ch%0d long", ex.e, ch);
        end
      end
    end
  end

  initial begin
    int e0;
    int rel;
    int pn;
    int rn;
    int ln;
    int den;
    int bseq [9];
    logic [N-1:0] p;
    logic r;
    bseq = '{1, 0, 1, 1, 0, 1, 1, 1, 0};
    for (int ch = 0; ch < N; ch++) begin
      last_evt[ch] = 0; press_at[ch] = -1;
      press_e[ch] = 0; rel_e[ch] = 0; long_e[ch] = 0;
      press_n[ch] = 0; rel_n[ch] = 0; long_n[ch] = 0;
    end
    rst = 1'b1;
    pb  = '0;

    // Reset with all buttons held, then release reset.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111);
    rel = edge_n;
    run(10, 4'b1111);
    for (int ch = 0; ch < N; ch++) check($sformatf("reset_press_edge_ch%0d", ch), press_e[ch], rel + 6);
    run(12, 4'b0000);

    // Clean press / release on ch0.
    e0 = edge_n + 1;
    run(20, 4'b0001);
    run(15, 4'b0000);
    check("ch0_press_edge", press_e[0], e0 + 5);
    check("ch0_release_edge", rel_e[0], e0 + 25);

    // Bounce on ch1 never stable for ST cycles.
    pn = press_n[1];
    rn = rel_n[1];
    for (int i = 0; i < 9; i++) step(1'b0, {2'b00, bseq[i][0], 1'b0});
    run(10, 4'b0000);
    check("ch1_bounce_press_count", press_n[1], pn);
    check("ch1_bounce_release_count", rel_n[1], rn);

    // Long press on ch2, then a short press.
    ln = long_n[2];
    e0 = edge_n + 1;
    run(40, 4'b0100);
    run(12, 4'b0000);
    check("ch2_press_edge", press_e[2], e0 + 5);
    check("ch2_long_count", long_n[2], ln + 1);
    check("ch2_long_delay", long_e[2] - press_e[2], HOLD - 1);
    check("ch2_release_edge", rel_e[2], e0 + 45);
    ln = long_n[2];
    pn = press_n[2];
    run(5, 4'b0100);
    run(15, 4'b0000);
    check("ch2_short_press_count", press_n[2], pn + 1);
    check("ch2_short_no_long", long_n[2], ln);

    // Channel independence: ch0 press and ch3 release on the same edge.
    run(10, 4'b1000);
    e0 = edge_n + 1;
    run(12, 4'b0001);
    check("indep_ch0_press", press_e[0], e0 + 5);
    check("indep_ch3_release", rel_e[3], e0 + 5);
    run(12, 4'b0000);

    // Reset three cycles after a press with the button still held.
    e0 = edge_n + 1;
    run(8, 4'b0100);
    step(1'b1, 4'b0100);
    rel = edge_n;
    run(20, 4'b0100);
    run(10, 4'b0000);
    check("midhold_repress_edge", press_e[2], rel + 6);
    check("midhold_long_edge", long_e[2], rel + 15);

    // Randomised mix of bounces, long holds and occasional resets.
    p   = '0;
    den = 6;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) den = int'($urandom_range(3, 25));
      r = ($urandom_range(0, 299) == 0);
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, den - 1) == 0) p[ch] = ~p[ch];
      step(r, p);
    end
    run(30, 4'b0000);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
